gpio_access_arbiter: RTL
========================

GPIO_ACCESS_ARBITER -- requirements
Module: gpio_access_arbiter

Interface
REQ-001 SHALL have parameter NR_GPIOS, default 3, number of GPIO bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  transaction request, requester 0 (JTAG bridge) / requester 1 (local sequencer).
REQ-005 SHALL have ports wr0/wr1  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports wdata0/wdata1  input  NR_GPIOS  output values to write.
REQ-007 SHALL have ports oe0/oe1  input  NR_GPIOS  output-enable values to write.
REQ-008 SHALL have ports mask0/mask1  input  NR_GPIOS  per-bit write mask.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle transaction-done pulse.
REQ-010 SHALL have ports rdata0/rdata1  output  NR_GPIOS  read result.
REQ-011 SHALL have ports gnt0/gnt1  output  1  current owner, one-hot or zero.
REQ-012 SHALL have port gpio_inputs  input  NR_GPIOS  asynchronous pad inputs.
REQ-013 SHALL have port gpio_outputs  output  NR_GPIOS  registered output values.
REQ-014 SHALL have port gpio_outputs_ena  output  NR_GPIOS  registered output enables.

Function
REQ-015 SHALL synchronize gpio_inputs through a 2-flop synchronizer before any use.
REQ-016 SHALL implement FSM IDLE -> ACCESS -> ACK -> IDLE, one cycle each in ACCESS and ACK.
REQ-017 IDLE: no request -> stay; one request -> grant it; both -> grant requester != last_grant; go to ACCESS.
REQ-018 SHALL assert gntN throughout ACCESS and ACK for owner N, and 0 in IDLE.
REQ-019 ACCESS, write: for each bit i with maskN[i]=1, gpio_outputs[i] <= wdataN[i] and gpio_outputs_ena[i] <= oeN[i]; unmasked bits are held.
REQ-020 ACCESS, read: rdataN <= synchronized inputs; GPIO registers are unchanged.
REQ-021 rdataN SHALL hold its value until the next read completes for that requester; a write SHALL leave rdataN unchanged.
REQ-022 ACK: ackN = 1 for exactly one cycle; last_grant <= N.
REQ-023 Latency: req sampled high in IDLE at edge E -> GPIO update at edge E+1 -> ack high between edges E+1 and E+2.
REQ-024 Requester SHALL hold wr/wdata/oe/mask stable from req assertion until ack; the arbiter samples them in ACCESS only.
REQ-025 req dropped during ACCESS SHALL NOT abort: the transaction completes and ack is still pulsed.
REQ-026 req held high through ACK SHALL be treated as a new request in the following IDLE, allowing back-to-back transfers at 3 cycles each.
REQ-027 Two continuous requesters SHALL alternate strictly; starvation SHALL be impossible.
REQ-028 Requests in ACCESS/ACK from the non-owner SHALL wait; they are not lost if held.

Reset
REQ-029 Reset SHALL force FSM=IDLE, gpio_outputs=0, gpio_outputs_ena=0, rdata0/1=0, ack0/1=0, gnt0/1=0, synchronizer=0, last_grant=1 (requester 0 wins the first tie).
REQ-030 Reset asserted mid-transaction SHALL abort it immediately with no ack; a write in ACK already applied SHALL be cleared by reset.

Configuration
REQ-031 With GPIO_ARB_LOCK_EN defined: inputs lock0/lock1 (1 bit) exist; if the owner's lockN=1 during ACK and reqN=1 in the next IDLE, N SHALL be regranted regardless of the other request.
REQ-032 Without GPIO_ARB_LOCK_EN: lock ports SHALL be absent and arbitration is pure round-robin per REQ-017.

Verification
REQ-033 Reset, req0 write wdata=3'b101 oe=3'b111 mask=3'b111 -> gpio_outputs=101, ena=111, ack0 two cycles after req is sampled.
REQ-034 gpio_outputs=101, req1 write wdata=010 mask=010 -> gpio_outputs=111, ena unchanged, ack1 only.
REQ-035 gpio_inputs=3'b100 stable, req0 read -> rdata0=100 with ack0; rdata1 unchanged.
REQ-036 req0 and req1 both held high for 12 cycles from reset -> grant order 0,1,0,1; 4 acks total, each 3 cycles apart.
REQ-037 Assert reset during ACCESS of a write -> no ack, all outputs 0, FSM IDLE; with GPIO_ARB_LOCK_EN, lock0=1 with both requesting -> requester 0 regranted consecutively.

Source files
------------

// File: rtl/gpio_access_arbiter.sv
// rtl/gpio_access_arbiter.sv - two-requester arbiter for a shared GPIO register bank
//
// Purpose:
//   Arbitrates between requester 0 (JTAG bridge) and requester 1 (local
//   sequencer) for read/write access to a bank of NR_GPIOS output and
//   output-enable registers. Each transaction runs IDLE -> ACCESS -> ACK.
//   When both requesters ask at once, the one that did not go last wins.
//
// Optional feature:
//   GPIO_ARB_LOCK_EN - adds lock0/lock1. If the owner holds lock high during
//   ACK and still requests in the following IDLE cycle, it is granted again.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   lock0/lock1      (GPIO_ARB_LOCK_EN only) keep ownership for the next transfer
//   req0/req1        transaction request
//   wr0/wr1          1 = write, 0 = read
//   wdata0/wdata1    output values to write
//   oe0/oe1          output-enable values to write
//   mask0/mask1      per-bit write mask
//   ack0/ack1        one-cycle transaction-done pulse
//   rdata0/rdata1    last read result for each requester
//   gnt0/gnt1        current owner (one-hot or zero)
//   gpio_inputs      asynchronous pad inputs
//   gpio_outputs     registered output values
//   gpio_outputs_ena registered output enables

module gpio_access_arbiter #(
    parameter int NR_GPIOS = 3
) (
    input  logic                clk,
    input  logic                reset,
`ifdef GPIO_ARB_LOCK_EN
    input  logic                lock0,
    input  logic                lock1,
`endif
    input  logic                req0,
    input  logic                req1,
    input  logic                wr0,
    input  logic                wr1,
    input  logic [NR_GPIOS-1:0] wdata0,
    input  logic [NR_GPIOS-1:0] wdata1,
    input  logic [NR_GPIOS-1:0] oe0,
    input  logic [NR_GPIOS-1:0] oe1,
    input  logic [NR_GPIOS-1:0] mask0,
    input  logic [NR_GPIOS-1:0] mask1,
    output logic                ack0,
    output logic                ack1,
    output logic [NR_GPIOS-1:0] rdata0,
    output logic [NR_GPIOS-1:0] rdata1,
    output logic                gnt0,
    output logic                gnt1,
    input  logic [NR_GPIOS-1:0] gpio_inputs,
    output logic [NR_GPIOS-1:0] gpio_outputs,
    output logic [NR_GPIOS-1:0] gpio_outputs_ena
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              state;
    logic                owner;
    logic                last_grant;
    logic                pick;
    logic [NR_GPIOS-1:0] sync_meta;
    logic [NR_GPIOS-1:0] sync_in;

    logic                sel_wr;
    logic [NR_GPIOS-1:0] sel_wdata;
    logic [NR_GPIOS-1:0] sel_oe;
    logic [NR_GPIOS-1:0] sel_mask;

`ifdef GPIO_ARB_LOCK_EN
    // Set on leaving ACK when the owner asked to keep the bus; only
    // meaningful in the first IDLE cycle after that transfer.
    logic                lock_hold;
`endif

    // Winner for a request seen in IDLE: a lone requester wins outright,
    // a tie goes to whoever did not own the previous transfer.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1;
        end
`ifdef GPIO_ARB_LOCK_EN
        if (lock_hold && (last_grant ? req1 : req0)) begin
            pick = last_grant;
        end
`endif
    end

    // Transaction fields of the current owner.
    always_comb begin
        sel_wr    = owner ? wr1    : wr0;
        sel_wdata = owner ? wdata1 : wdata0;
        sel_oe    = owner ? oe1    : oe0;
        sel_mask  = owner ? mask1  : mask0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            owner            <= 1'b0;
            last_grant       <= 1'b1;
            sync_meta        <= '0;
            sync_in          <= '0;
            gpio_outputs     <= '0;
            gpio_outputs_ena <= '0;
            rdata0           <= '0;
            rdata1           <= '0;
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            gnt0             <= 1'b0;
            gnt1             <= 1'b0;
`ifdef GPIO_ARB_LOCK_EN
            lock_hold        <= 1'b0;
`endif
        end else begin
            sync_meta <= gpio_inputs;
            sync_in   <= sync_meta;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            case (state)
                IDLE: begin
`ifdef GPIO_ARB_LOCK_EN
                    lock_hold <= 1'b0;
`endif
                    if (req0 || req1) begin
                        owner <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (sel_wr) begin
                        gpio_outputs     <= (gpio_outputs & ~sel_mask) | (sel_wdata & sel_mask);
                        gpio_outputs_ena <= (gpio_outputs_ena & ~sel_mask) | (sel_oe & sel_mask);
                    end else if (owner) begin
                        rdata1 <= sync_in;
                    end else begin
                        rdata0 <= sync_in;
                    end
                    ack0  <= ~owner;
                    ack1  <= owner;
                    state <= ACK;
                end
                ACK: begin
                    last_grant <= owner;
                    gnt0       <= 1'b0;
                    gnt1       <= 1'b0;
`ifdef GPIO_ARB_LOCK_EN
                    lock_hold  <= owner ? lock1 : lock0;
`endif
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
